ram_helper_arbiter: RTL
=======================

# ram_helper_arbiter

Round-robin arbiter that shares the single simulation `RAMHelper` port among `NUM_REQ` requesters, for example the instruction-fetch and data-load/store paths of the simulation SoC. Each requester has a valid/ready request channel and a valid/ready response channel. The block translates byte addresses to 64-bit word indices and drives the RAM's combinational read port and clocked write port. Each granted access returns one registered response, with at most one response outstanding at a time.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `BASE_ADDR`, default 64'h8000_0000: byte address that maps to RAM word index 0.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous assert, active-low, released synchronously to `clk`.
- `req_valid` in NUM_REQ: request valid, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle; one-hot or zero.
- `req_addr` in 64*NUM_REQ: byte address; requester i uses slice [64i+63:64i].
- `req_wdata` in 64*NUM_REQ: write data.
- `req_wmask` in 64*NUM_REQ: bit-granular write mask.
- `req_wen` in NUM_REQ: 1 = write, 0 = read.
- `resp_valid` out NUM_REQ: response valid to the owning requester; one-hot or zero.
- `resp_ready` in NUM_REQ: response accepted.
- `resp_rdata` out 64: response data, shared by all requesters.
- `ram_en` out 1: drives RAM `en`.
- `ram_rIdx` out 64: read word index.
- `ram_rdata` in 64: combinational read data from the RAM.
- `ram_wIdx` out 64: write word index.
- `ram_wdata` out 64: write data.
- `ram_wmask` out 64: write mask.
- `ram_wen` out 1: write enable. The RAM commits a write only when `ram_wen` and `ram_en` are both high at the rising edge of `clk`.

## Operation
- **State machine, two states.**
  - IDLE: no response is pending.
  - RESP: a response is held, with `resp_valid[owner]` high.
- **Grant eligibility.** A grant may be issued when the block is in IDLE, or when it is in RESP and `resp_ready[owner]` is high in the same cycle (back-to-back operation).
- **Arbitration.** Round-robin over the asserted `req_valid` bits.
  - Search starts at index `last+1` and wraps modulo NUM_REQ.
  - `last` updates to the granted index on every grant.
  - Reset value of `last` is NUM_REQ-1, so requester 0 wins first.
- **Grant cycle.** `req_ready[g]` = 1 and `ram_en` = 1.
- **Index calculation.** `ram_rIdx` = `ram_wIdx` = (`req_addr[g]` - `BASE_ADDR`) >> 3.
  - The subtraction is 64-bit modulo 2^64, with no range check.
  - Address bits [2:0] are ignored.
- **Write fields.** `ram_wdata`, `ram_wmask` and `ram_wen` are taken from requester g.
- **Idle RAM outputs.** When there is no grant, `ram_en` = 0 and `ram_wen` = 0. All other RAM outputs are don't-care but must be driven, not X; tie them to requester 0's fields.
- **Response capture.** At the grant edge, `ram_rdata` is registered into `resp_rdata`, `owner` is set to g, and the state moves to RESP.
  - For a write, the captured data is the word's value before the write takes effect.
- **RESP hold.** `resp_valid[owner]` and `resp_rdata` stay stable until `resp_ready[owner]` is sampled high.
  - If no new grant occurs that cycle, the state returns to IDLE.
  - If a new grant occurs that cycle, the state stays in RESP with the new owner and data.
- **Ignored inputs.** `resp_ready` bits of non-owner requesters are ignored.
- **Request persistence.** A request with `req_valid` high and `req_ready` low is not lost. The requester must hold it, and the arbiter must not assume it will be held.
- **Reset values.** While `rst_n` = 0, all outputs are held at their reset values asynchronously; `ram_en` is gated by reset.
  - `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0, `ram_en` = 0, `ram_wen` = 0, state = IDLE.
  - A response pending at reset is discarded.

## Timing
- **Request-to-response latency.** Exactly 1 cycle: a grant at edge N produces `resp_valid` visible in cycle N+1.
- **Throughput.** One access per cycle while the owner keeps `resp_ready` high.
- **Combinational paths.**
  - `req_ready` depends combinationally on `req_valid`, the state, and `resp_ready[owner]`.
  - `ram_*` outputs depend combinationally on the grant.
  - `resp_*` outputs are registered only.
- **Write-then-read ordering.** A write granted at edge N is committed by the RAM at that edge. A read granted in cycle N+1 or later returns the new data.
- **Fairness.** With all requesters continuously valid, each is granted exactly once every NUM_REQ grants.
- **Reset mid-transfer.**
  - A grant whose edge coincides with reset assertion is not captured.
  - Whether that write reaches the RAM is undefined; the bench must not rely on it.

## Test plan
- **Single read.** After reset, requester 0 reads 0x8000_0010 with RAM word 2 = 0xDEAD → `ram_en` = 1 and `ram_rIdx` = 2 in the grant cycle; next cycle `resp_valid` = 2'b01 and `resp_rdata` = 0xDEAD.
- **Write then read.** Requester 1 writes 0x1122_3344_5566_7788 to 0x8000_0008 with mask all ones (returns the old data). Requester 1 then reads 0x8000_0008 → `resp_rdata` = 0x1122_3344_5566_7788. A second write to the same word with mask 0xFF carrying 0xAA, followed by a read → 0x1122_3344_5566_77AA.
- **Round-robin.** Both requesters continuously valid, `resp_ready` tied high → grants alternate 0,1,0,1,… and one `resp_valid` per cycle after the first.
- **Backpressure.** Owner holds `resp_ready` = 0 for 5 cycles while the other requester is valid → `req_ready` = 0 throughout and `resp_rdata` stable. The other requester is granted in the same cycle `resp_ready` rises.
- **Reset mid-operation.** Drop `rst_n` while in RESP → `resp_valid` = 0 and `ram_en` = 0 immediately (asynchronous). After release, the first grant goes to requester 0.
- **Address wrap.** Request address 0x0000_0000_0000_0008 → `ram_rIdx` = 0x1FFF_FFFF_F000_0001.

Source files
------------

// File: rtl/ram_helper_arbiter.sv
// Round-robin arbiter sharing one RAMHelper port among NUM_REQ valid/ready requesters.
// Each grant produces exactly one registered response, and only one response is outstanding at a time.
module ram_helper_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_addr,
    input  logic [64*NUM_REQ-1:0]   req_wdata,
    input  logic [64*NUM_REQ-1:0]   req_wmask,
    input  logic [NUM_REQ-1:0]      req_wen,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [63:0]             resp_rdata,
    output logic                    ram_en,
    output logic [63:0]             ram_rIdx,
    input  logic [63:0]             ram_rdata,
    output logic [63:0]             ram_wIdx,
    output logic [63:0]             ram_wdata,
    output logic [63:0]             ram_wmask,
    output logic                    ram_wen
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       last_q;
    logic [63:0]            resp_rdata_q;
    logic [NUM_REQ-1:0]     resp_valid_q;

    logic                   eligible_s;
    logic                   pick_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic                   grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [NUM_REQ-1:0]     grant_onehot_s;
    logic [63:0]            sel_addr_s;
    logic [63:0]            sel_wdata_s;
    logic [63:0]            sel_wmask_s;
    logic                   sel_wen_s;

    // Round-robin pick: scan farthest-to-nearest from last+1 so the nearest valid requester wins.
    always_comb begin
        pick_s     = 1'b0;
        pick_idx_s = '0;
        cand_s     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s     = IDX_W'((int'(last_q) + k) % NUM_REQ);
            pick_s     = pick_s | req_valid[cand_s];
            pick_idx_s = req_valid[cand_s] ? cand_s : pick_idx_s;
        end
    end

    // Grant qualification: idle, or the current owner is draining its response this cycle.
    always_comb begin
        eligible_s     = (state_q == ST_IDLE) || resp_ready[owner_q];
        grant_s        = pick_s && eligible_s && rst_n;
        grant_idx_s    = grant_s ? pick_idx_s : '0;
        grant_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot_s[i] = grant_s && (grant_idx_s == IDX_W'(i));
        end
    end

    // Field mux: without a grant the index is 0, so requester 0's fields keep the RAM port defined.
    always_comb begin
        sel_addr_s  = req_addr[63:0];
        sel_wdata_s = req_wdata[63:0];
        sel_wmask_s = req_wmask[63:0];
        sel_wen_s   = req_wen[0];
        for (int i = 1; i < NUM_REQ; i++) begin
            sel_addr_s  = (grant_idx_s == IDX_W'(i)) ? req_addr[64*i +: 64]  : sel_addr_s;
            sel_wdata_s = (grant_idx_s == IDX_W'(i)) ? req_wdata[64*i +: 64] : sel_wdata_s;
            sel_wmask_s = (grant_idx_s == IDX_W'(i)) ? req_wmask[64*i +: 64] : sel_wmask_s;
            sel_wen_s   = (grant_idx_s == IDX_W'(i)) ? req_wen[i]            : sel_wen_s;
        end
    end

    // RAM port and request handshake outputs; subtraction wraps modulo 2^64 by design.
    always_comb begin
        req_ready  = grant_onehot_s;
        ram_en     = grant_s;
        ram_wen    = grant_s && sel_wen_s;
        ram_rIdx   = (sel_addr_s - BASE_ADDR) >> 3'd3;
        ram_wIdx   = (sel_addr_s - BASE_ADDR) >> 3'd3;
        ram_wdata  = sel_wdata_s;
        ram_wmask  = sel_wmask_s;
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
    end

    // Response FSM: capture read data on every grant, release on the owner's resp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            resp_rdata_q <= 64'h0;
            resp_valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_q      <= ST_RESP;
                        owner_q      <= grant_idx_s;
                        last_q       <= grant_idx_s;
                        resp_rdata_q <= ram_rdata;
                        resp_valid_q <= grant_onehot_s;
                    end else begin
                        resp_valid_q <= '0;
                    end
                end
                ST_RESP: begin
                    if (grant_s) begin
                        owner_q      <= grant_idx_s;
                        last_q       <= grant_idx_s;
                        resp_rdata_q <= ram_rdata;
                        resp_valid_q <= grant_onehot_s;
                    end else if (resp_ready[owner_q]) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= '0;
                    end else begin
                        state_q      <= ST_RESP;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= '0;
                end
            endcase
        end
    end

endmodule
